// File: rtl/bpm_pkg.sv
// -----------------------------------------------------------------------------
// bpm_pkg
// Shared constants and types for the BPM packet parser.
// A BPM packet is four 32-bit beats: header, X, Y, sum.
//   header[31:16] magic, [15] FOFB enable, [14:10] cell index, [8:0] FOFB index
// -----------------------------------------------------------------------------
package bpm_pkg;

  localparam logic [15:0] BPM_MAGIC     = 16'hA5BE;
  localparam int          BPM_PKT_WORDS = 4;

  // Header field bit positions
  localparam int MAGIC_HI    = 31;
  localparam int MAGIC_LO    = 16;
  localparam int FOFB_EN_BIT = 15;
  localparam int CELL_HI     = 14;
  localparam int CELL_LO     = 10;
  localparam int IDX_HI      = 8;
  localparam int IDX_LO      = 0;

  // One state per packet word plus a drop state
  localparam int ST_W = $clog2(BPM_PKT_WORDS + 1);

  typedef enum logic [ST_W-1:0] {
    ST_HDR,
    ST_PX,
    ST_PY,
    ST_PS,
    ST_DROP
  } bpm_state_e;

  function automatic logic magic_ok(input logic [31:0] word);
    return (word[MAGIC_HI:MAGIC_LO] == BPM_MAGIC);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset, clears the count
//   inc    in  count one event this cycle
//   count  out current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count register, holds once all-ones is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/bpm_packet_parser.sv
// -----------------------------------------------------------------------------
// bpm_packet_parser
// Parses 4-beat BPM packets from a non-stalling AXI-Stream source into
// registered position fields with a one-cycle valid strobe, and keeps
// saturating status counters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   s_tdata/s_tvalid/s_tlast         input stream (no backpressure)
//   out_valid                        strobe, one cycle after a good sum beat
//   out_fofb_en/out_cell_index/
//   out_fofb_index                   header fields
//   out_x/out_y                      signed positions (nm)
//   out_sum/out_flags                sum word [29:0] / {CRC fault, ADC clip}
//   cnt_good, cnt_bad_magic,
//   cnt_bad_len, cnt_bad_index       status counters (CNT_W bits)
// Configuration:
//   BPM_PARSER_ERR_COUNT_EN  when defined, the three error counters are
//                            implemented; otherwise they read as zero.
// -----------------------------------------------------------------------------
module bpm_packet_parser
  import bpm_pkg::*;
#(
  parameter int FOFB_INDEX_MAX = 511,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             out_valid,
  output logic             out_fofb_en,
  output logic [4:0]       out_cell_index,
  output logic [8:0]       out_fofb_index,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic [29:0]      out_sum,
  output logic [1:0]       out_flags,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad_magic,
  output logic [CNT_W-1:0] cnt_bad_len,
  output logic [CNT_W-1:0] cnt_bad_index
);

  bpm_state_e  r_state;
  bpm_state_e  w_next_state;

  logic        r_hdr_fofb_en;
  logic [4:0]  r_hdr_cell;
  logic [8:0]  r_hdr_idx;
  logic [31:0] r_x;
  logic [31:0] r_y;

  logic        r_out_valid;
  logic        r_out_fofb_en;
  logic [4:0]  r_out_cell;
  logic [8:0]  r_out_idx;
  logic [31:0] r_out_x;
  logic [31:0] r_out_y;
  logic [29:0] r_out_sum;
  logic [1:0]  r_out_flags;

  logic        w_lat_hdr;
  logic        w_lat_x;
  logic        w_lat_y;
  logic        w_complete;
  logic        w_idx_ok;
  logic        w_inc_good;
  logic        w_inc_bad_magic;
  logic        w_inc_bad_len;
  logic        w_inc_bad_index;

  // The index check uses the header latched earlier in this packet
  assign w_idx_ok = (32'(r_hdr_idx) <= FOFB_INDEX_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, field latch enables and per-beat counter events
  always_comb begin
    w_next_state    = r_state;
    w_lat_hdr       = 1'b0;
    w_lat_x         = 1'b0;
    w_lat_y         = 1'b0;
    w_complete      = 1'b0;
    w_inc_bad_magic = 1'b0;
    w_inc_bad_len   = 1'b0;
    if (s_tvalid) begin
      case (r_state)
        ST_HDR: begin
          // A lone header beat is a length error even if the magic is wrong
          if (s_tlast) begin
            w_inc_bad_len = 1'b1;
            w_next_state  = ST_HDR;
          end else if (!magic_ok(s_tdata)) begin
            w_inc_bad_magic = 1'b1;
            w_next_state    = ST_DROP;
          end else begin
            w_lat_hdr    = 1'b1;
            w_next_state = ST_PX;
          end
        end
        ST_PX: begin
          if (s_tlast) begin
            w_inc_bad_len = 1'b1;
            w_next_state  = ST_HDR;
          end else begin
            w_lat_x      = 1'b1;
            w_next_state = ST_PY;
          end
        end
        ST_PY: begin
          if (s_tlast) begin
            w_inc_bad_len = 1'b1;
            w_next_state  = ST_HDR;
          end else begin
            w_lat_y      = 1'b1;
            w_next_state = ST_PS;
          end
        end
        ST_PS: begin
          // Overlong packet: counted once here, remainder dropped silently
          if (s_tlast) begin
            w_complete   = 1'b1;
            w_next_state = ST_HDR;
          end else begin
            w_inc_bad_len = 1'b1;
            w_next_state  = ST_DROP;
          end
        end
        ST_DROP: begin
          if (s_tlast) begin
            w_next_state = ST_HDR;
          end else begin
            w_next_state = ST_DROP;
          end
        end
        default: begin
          w_next_state = ST_HDR;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
    w_inc_good      = w_complete & w_idx_ok;
    w_inc_bad_index = w_complete & ~w_idx_ok;
  end

  // Header, X and Y capture while the packet is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_fofb_en <= 1'b0;
      r_hdr_cell    <= 5'd0;
      r_hdr_idx     <= 9'd0;
      r_x           <= 32'd0;
      r_y           <= 32'd0;
    end else begin
      if (w_lat_hdr) begin
        r_hdr_fofb_en <= s_tdata[FOFB_EN_BIT];
        r_hdr_cell    <= s_tdata[CELL_HI:CELL_LO];
        r_hdr_idx     <= s_tdata[IDX_HI:IDX_LO];
      end
      if (w_lat_x) begin
        r_x <= s_tdata;
      end
      if (w_lat_y) begin
        r_y <= s_tdata;
      end
    end
  end

  // Output strobe and field registers; fields change only with the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_fofb_en <= 1'b0;
      r_out_cell    <= 5'd0;
      r_out_idx     <= 9'd0;
      r_out_x       <= 32'd0;
      r_out_y       <= 32'd0;
      r_out_sum     <= 30'd0;
      r_out_flags   <= 2'd0;
    end else begin
      r_out_valid <= w_inc_good;
      if (w_inc_good) begin
        r_out_fofb_en <= r_hdr_fofb_en;
        r_out_cell    <= r_hdr_cell;
        r_out_idx     <= r_hdr_idx;
        r_out_x       <= r_x;
        r_out_y       <= r_y;
        r_out_sum     <= s_tdata[29:0];
        r_out_flags   <= s_tdata[31:30];
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_fofb_en    = r_out_fofb_en;
  assign out_cell_index = r_out_cell;
  assign out_fofb_index = r_out_idx;
  assign out_x          = r_out_x;
  assign out_y          = r_out_y;
  assign out_sum        = r_out_sum;
  assign out_flags      = r_out_flags;

  sat_counter #(.WIDTH(CNT_W)) u_cnt_good (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_good),
    .count (cnt_good)
  );

`ifdef BPM_PARSER_ERR_COUNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_cnt_bad_magic (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_bad_magic),
    .count (cnt_bad_magic)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_bad_len (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_bad_len),
    .count (cnt_bad_len)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_bad_index (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_bad_index),
    .count (cnt_bad_index)
  );
`else
  logic w_unused_err;
  assign w_unused_err  = ^{w_inc_bad_magic, w_inc_bad_len, w_inc_bad_index};
  assign cnt_bad_magic = '0;
  assign cnt_bad_len   = '0;
  assign cnt_bad_index = '0;
`endif

endmodule

// File: tb/tb_bpm_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_bpm_packet_parser
// Drives two parser instances (default parameters, and FOFB_INDEX_MAX=7 with
// 2-bit counters) from one stream. Each packet is classified from its length
// and header alone, and the expected strobe, fields and counters follow from
// that classification.
// -----------------------------------------------------------------------------
module tb_bpm_packet_parser;

`ifdef BPM_PARSER_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int K_GOOD  = 0;
  localparam int K_MAGIC = 1;
  localparam int K_LEN   = 2;
  localparam int K_INDEX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;

  logic        a_valid, a_en, b_valid, b_en;
  logic [4:0]  a_cell, b_cell;
  logic [8:0]  a_idx, b_idx;
  logic [31:0] a_x, a_y, b_x, b_y;
  logic [29:0] a_sum, b_sum;
  logic [1:0]  a_flags, b_flags;
  logic [15:0] a_good, a_bm, a_bl, a_bi;
  logic [1:0]  b_good, b_bm, b_bl, b_bi;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt[2][4];
  int          max_idx[2] = '{511, 7};
  int          cnt_max[2] = '{65535, 3};
  logic [110:0] exp_fields[2];
  logic [31:0] pkt_q[$];

  always #5 clk = ~clk;

  bpm_packet_parser u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .out_valid(a_valid), .out_fofb_en(a_en), .out_cell_index(a_cell), .out_fofb_index(a_idx),
    .out_x(a_x), .out_y(a_y), .out_sum(a_sum), .out_flags(a_flags),
    .cnt_good(a_good), .cnt_bad_magic(a_bm), .cnt_bad_len(a_bl), .cnt_bad_index(a_bi)
  );

  bpm_packet_parser #(.FOFB_INDEX_MAX(7), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .out_valid(b_valid), .out_fofb_en(b_en), .out_cell_index(b_cell), .out_fofb_index(b_idx),
    .out_x(b_x), .out_y(b_y), .out_sum(b_sum), .out_flags(b_flags),
    .cnt_good(b_good), .cnt_bad_magic(b_bm), .cnt_bad_len(b_bl), .cnt_bad_index(b_bi)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet classification straight from the framing rules
  function automatic int classify(input int len, input logic [31:0] hdr, input int maxi);
    if (len == 1) return K_LEN;
    if (hdr[31:16] != 16'hA5BE) return K_MAGIC;
    if (len != 4) return K_LEN;
    if (int'(hdr[8:0]) > maxi) return K_INDEX;
    return K_GOOD;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_fields[d] = '0;
      for (int k = 0; k < 4; k++) exp_cnt[d][k] = 0;
    end
  endtask

  task automatic check_cycle(input bit va, input bit vb);
    check_val("a_valid", a_valid, va);
    check_val("a_fields", {a_en, a_cell, a_idx, a_x, a_y, a_sum, a_flags}, exp_fields[0]);
    check_val("b_valid", b_valid, vb);
    check_val("b_fields", {b_en, b_cell, b_idx, b_x, b_y, b_sum, b_flags}, exp_fields[1]);
  endtask

  task automatic check_counters();
    check_val("a_cnt_good", a_good, exp_cnt[0][K_GOOD]);
    check_val("a_cnt_bad_magic", a_bm, ERR_EN ? exp_cnt[0][K_MAGIC] : 0);
    check_val("a_cnt_bad_len", a_bl, ERR_EN ? exp_cnt[0][K_LEN] : 0);
    check_val("a_cnt_bad_index", a_bi, ERR_EN ? exp_cnt[0][K_INDEX] : 0);
    check_val("b_cnt_good", b_good, exp_cnt[1][K_GOOD]);
    check_val("b_cnt_bad_magic", b_bm, ERR_EN ? exp_cnt[1][K_MAGIC] : 0);
    check_val("b_cnt_bad_len", b_bl, ERR_EN ? exp_cnt[1][K_LEN] : 0);
    check_val("b_cnt_bad_index", b_bi, ERR_EN ? exp_cnt[1][K_INDEX] : 0);
  endtask

  task automatic idle_cycle();
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    s_tlast  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_cycle(1'b0, 1'b0);
  endtask

  task automatic build_pkt(input logic [31:0] hdr, input int len);
    pkt_q.delete();
    pkt_q.push_back(hdr);
    for (int i = 1; i < len; i++) pkt_q.push_back($urandom);
  endtask

  // Sends the queued packet beat by beat, checking every cycle
  task automatic send_pkt(input bit gaps);
    int len;
    int kind[2];
    bit ev[2];
    len = pkt_q.size();
    for (int d = 0; d < 2; d++) kind[d] = classify(len, pkt_q[0], max_idx[d]);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 3)) idle_cycle();
      s_tdata  = pkt_q[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == len - 1);
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        ev[d] = (i == 3) && (kind[d] == K_GOOD);
        if (ev[d]) exp_fields[d] = {pkt_q[0][15], pkt_q[0][14:10], pkt_q[0][8:0],
                                    pkt_q[1], pkt_q[2], pkt_q[3][29:0], pkt_q[3][31:30]};
      end
      check_cycle(ev[0], ev[1]);
    end
    s_tvalid = 1'b0;
    for (int d = 0; d < 2; d++)
      if (exp_cnt[d][kind[d]] < cnt_max[d]) exp_cnt[d][kind[d]]++;
    check_counters();
  endtask

  function automatic logic [31:0] good_hdr(input logic [8:0] idx);
    return {16'hA5BE, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), idx};
  endfunction

  initial begin
    logic [31:0] hdr;
    rst_n    = 1'b0;
    s_tdata  = 32'd0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cycle(1'b0, 1'b0);
    check_counters();
    rst_n = 1'b1;

    // Single good packet with hand-computed fields
    pkt_q = '{32'hA5BE_8C05, 32'h0000_00FF, 32'h0000_FF00, 32'hC0FF_0000};
    send_pkt(1'b0);
    check_val("one_cell", a_cell, 5'd3);
    check_val("one_idx", a_idx, 9'd5);
    check_val("one_en", a_en, 1'b1);
    check_val("one_flags", a_flags, 2'b11);
    check_val("one_sum", a_sum, 30'h00FF_0000);
    check_val("one_good", a_good, 16'd1);

    // Eight back-to-back packets, continuous tvalid
    for (int p = 0; p < 8; p++) begin
      build_pkt(good_hdr(9'(p)), 4);
      send_pkt(1'b0);
    end
    check_val("b2b_good", a_good, 16'd9);

    // Bad magic, then good
    build_pkt(32'h1234_0000, 4);
    send_pkt(1'b0);
    build_pkt(good_hdr(9'd20), 4);
    send_pkt(1'b0);

    // Short and long packets, then good
    build_pkt(good_hdr(9'd1), 3);
    send_pkt(1'b0);
    build_pkt(good_hdr(9'd2), 5);
    send_pkt(1'b0);
    build_pkt(good_hdr(9'd3), 4);
    send_pkt(1'b0);
    check_val("len_bad_len", a_bl, ERR_EN ? 16'd2 : 16'd0);

    // Index just above the small instance's limit; then counter saturation
    build_pkt(good_hdr(9'd8), 4);
    send_pkt(1'b0);
    check_val("idx_b_bad_index", b_bi, ERR_EN ? 2'd1 : 2'd0);
    for (int p = 0; p < 5; p++) begin
      build_pkt({16'h0BAD, 16'($urandom)}, 4);
      send_pkt(1'b0);
    end
    check_val("sat_b_bad_magic", b_bm, ERR_EN ? 2'd3 : 2'd0);

    // Reset during the Y beat, then a fresh packet
    hdr = good_hdr(9'd6);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = hdr;
    @(posedge clk); #1;
    check_cycle(1'b0, 1'b0);
    s_tdata = $urandom;
    @(posedge clk); #1;
    check_cycle(1'b0, 1'b0);
    s_tdata = $urandom;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_cycle(1'b0, 1'b0);
    check_counters();
    @(posedge clk); #1;
    check_cycle(1'b0, 1'b0);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    build_pkt(good_hdr(9'd4), 4);
    send_pkt(1'b0);

    // Randomized traffic with idle gaps
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 3) != 0)
        hdr = good_hdr(($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511)));
      else
        hdr = $urandom;
      build_pkt(hdr, $urandom_range(1, 6));
      send_pkt(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
